bitrev_reorder_buffer: RTL

BITREV_REORDER_BUFFER -- requirements
Module: bitrev_reorder_buffer

---
 rtl/bitrev_reorder_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/bitrev_reorder_buffer.sv
// rtl/bitrev_reorder_buffer.sv - ping-pong buffer turning bit-reversed frames into natural order
//
// Purpose: frames of N = 2^N_LOG2 words arrive in bit-reversed index order.
// Each word is written to bitreverse(arrival count) in the current write bank.
// A full bank is read out sequentially, so words leave in natural order. Two
// banks let one frame be written while the previous one drains.
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   EN           global enable, low freezes all state
//   i_VALID      input word present
//   i_DATA       input word
//   o_IN_READY   input accepted when high
//   o_VALID      output word present
//   o_DATA       output word (zero when o_VALID is low)
//   o_LAST       last word of an output frame
//   i_OUT_READY  downstream accepts the output word
module bitrev_reorder_buffer #(
    parameter int BITNESS = 16,
    parameter int N_LOG2  = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               i_VALID,
    input  logic [BITNESS-1:0] i_DATA,
    output logic               o_IN_READY,
    output logic               o_VALID,
    output logic [BITNESS-1:0] o_DATA,
    output logic               o_LAST,
    input  logic               i_OUT_READY
);

    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] CNT_MAX = N_LOG2'(N - 1);

    // Both banks in one array; the bank select is the address MSB.
    logic [BITNESS-1:0] mem [2*N];

    logic              wsel;
    logic              rsel;
    logic [N_LOG2-1:0] wcnt;
    logic [N_LOG2-1:0] rcnt;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic [N_LOG2-1:0] waddr;
    logic              wr_fire;
    logic              rd_fire;
    logic              wr_last;
    logic              rd_last;

    always_comb begin
        waddr = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            waddr[i] = wcnt[N_LOG2-1-i];
        end
    end

    // Ready and valid come from registered flags only; the writer never
    // looks at the reader's same-cycle release of a bank.
    assign o_IN_READY = ~full[wsel];
    assign o_VALID    = full[rsel];
    assign o_LAST     = o_VALID & (rcnt == CNT_MAX);
    assign o_DATA     = o_VALID ? mem[{rsel, rcnt}] : '0;

    assign wr_fire = EN & i_VALID & ~full[wsel];
    assign rd_fire = EN & full[rsel] & i_OUT_READY;
    assign wr_last = wr_fire & (wcnt == CNT_MAX);
    assign rd_last = rd_fire & (rcnt == CNT_MAX);

    // A writable bank is never full and a readable bank always is, so a
    // same-cycle set and clear always target different bits.
    always_comb begin
        full_nxt = full;
        if (rd_last) begin
            full_nxt[rsel] = 1'b0;
        end
        if (wr_last) begin
            full_nxt[wsel] = 1'b1;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            mem[{wsel, waddr}] <= i_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wsel <= 1'b0;
            rsel <= 1'b0;
            wcnt <= '0;
            rcnt <= '0;
            full <= 2'b00;
        end else begin
            if (wr_fire) begin
                wcnt <= wcnt + N_LOG2'(1);
                if (wcnt == CNT_MAX) begin
                    wsel <= ~wsel;
                end
            end
            if (rd_fire) begin
                rcnt <= rcnt + N_LOG2'(1);
                if (rcnt == CNT_MAX) begin
                    rsel <= ~rsel;
                end
            end
            full <= full_nxt;
        end
    end

endmodule
